// File: rtl/axis_arb_pkg.sv
// Shared constants and state encoding for the AXI-Stream burst arbiter.
package axis_arb_pkg;

  // Cycles spent after a burst so the FIFO write count reflects the last beats
  localparam int unsigned SETTLE_CYCLES = 2;
  localparam int unsigned SETTLE_W      = $clog2(SETTLE_CYCLES + 1);

  // Arbiter FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_GRANT  = 2'd1;
  localparam state_t ST_SETTLE = 2'd2;

endpackage : axis_arb_pkg

// File: rtl/axis_fifo_burst_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr, cyclically.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic               any,
  output logic [SRC_W-1:0]   idx
);

  localparam int unsigned CW = SRC_W + 1;

  logic [CW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest requester wins
  always_comb begin
    any  = |req;
    idx  = '0;
    cand = '0;
    for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(NUM_SRC)) begin
        cand = cand - CW'(NUM_SRC);
      end
      if (req[cand[SRC_W-1:0]]) begin
        idx = cand[SRC_W-1:0];
      end
    end
  end

endmodule : rr_pick

// File: rtl/axis_fifo_burst_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_SRC AXI-Stream producers.
module axis_fifo_burst_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned TDATA_WIDTH = 128,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned FIFO_DEPTH  = 256,
  parameter int unsigned SRC_W       = $clog2(NUM_SRC)
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [NUM_SRC*TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [NUM_SRC-1:0]             S_AXIS_TVALID,
  output logic [NUM_SRC-1:0]             S_AXIS_TREADY,
  output logic [TDATA_WIDTH-1:0]         M_AXIS_TDATA,
  output logic                           M_AXIS_TVALID,
  input  logic                           M_AXIS_TREADY,
  input  logic [31:0]                    fifo_data_count,
  output logic [SRC_W-1:0]               grant_id,
  output logic                           burst_active,
  output logic [31:0]                    burst_count
);

  localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
  localparam int unsigned CNT_W  = 32;

  state_t                state_q,        state_d;
  logic [SRC_W-1:0]      grant_id_q,     grant_id_d;
  logic [SRC_W-1:0]      rr_ptr_q,       rr_ptr_d;
  logic [BEAT_W-1:0]     beat_cnt_q,     beat_cnt_d;
  logic [SETTLE_W-1:0]   settle_cnt_q,   settle_cnt_d;
  logic [CNT_W-1:0]      burst_count_q,  burst_count_d;
  logic                  burst_active_q, burst_active_d;

  logic                  pick_any;
  logic [SRC_W-1:0]      pick_idx;
  logic [TDATA_WIDTH-1:0] src_data [NUM_SRC];
  logic                  in_grant;
  logic                  sel_valid;
  logic [CNT_W-1:0]      free_space;
  logic                  space_ok;
  logic                  last_beat;
  logic                  burst_done;

  // Split the flat source bus into per-source words
  for (genvar i = 0; i < int'(NUM_SRC); i++) begin : g_unpack
    assign src_data[i] = S_AXIS_TDATA[i*TDATA_WIDTH +: TDATA_WIDTH];
  end

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_rr_pick (
    .req (S_AXIS_TVALID),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Admission: room for a whole burst, unsigned 32-bit arithmetic
  assign free_space = CNT_W'(FIFO_DEPTH) - fifo_data_count;
  assign space_ok   = (free_space >= CNT_W'(BURST_LEN));

  assign in_grant   = (state_q == ST_GRANT);
  assign sel_valid  = S_AXIS_TVALID[grant_id_q];
  assign last_beat  = (beat_cnt_q == BEAT_W'(BURST_LEN - 1));
  // A burst ends on its final handshake or as soon as the owner stops presenting data
  assign burst_done = !sel_valid || (M_AXIS_TREADY && last_beat);

  // Zero-latency datapath while granted, quiet otherwise
  assign M_AXIS_TVALID = in_grant & sel_valid;
  assign M_AXIS_TDATA  = in_grant ? src_data[grant_id_q] : '0;

  // Only the granted source sees the FIFO ready
  always_comb begin
    S_AXIS_TREADY = '0;
    if (in_grant) begin
      S_AXIS_TREADY[grant_id_q] = M_AXIS_TREADY;
    end
  end

  // Next-state and counter update logic
  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    settle_cnt_d  = settle_cnt_q;
    burst_count_d = burst_count_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any && space_ok) begin
          grant_id_d = pick_idx;
          state_d    = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (burst_done) begin
          state_d       = ST_SETTLE;
          rr_ptr_d      = (grant_id_q == SRC_W'(NUM_SRC - 1)) ? '0 : grant_id_q + SRC_W'(1);
          burst_count_d = burst_count_q + CNT_W'(1);
          beat_cnt_d    = '0;
          settle_cnt_d  = '0;
        end else if (M_AXIS_TREADY) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end
      end

      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          state_d      = ST_IDLE;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
        end
      end

      default: begin
        state_d      = ST_IDLE;
        beat_cnt_d   = '0;
        settle_cnt_d = '0;
      end
    endcase

    burst_active_d = (state_d == ST_GRANT);
  end

  // State and counter registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= ST_IDLE;
      grant_id_q     <= '0;
      rr_ptr_q       <= '0;
      beat_cnt_q     <= '0;
      settle_cnt_q   <= '0;
      burst_count_q  <= '0;
      burst_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      rr_ptr_q       <= rr_ptr_d;
      beat_cnt_q     <= beat_cnt_d;
      settle_cnt_q   <= settle_cnt_d;
      burst_count_q  <= burst_count_d;
      burst_active_q <= burst_active_d;
    end
  end

  assign grant_id     = grant_id_q;
  assign burst_active = burst_active_q;
  assign burst_count  = burst_count_q;

endmodule : axis_fifo_burst_arbiter

// File: tb/tb_axis_fifo_burst_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_axis_fifo_burst_arbiter;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned TDW     = 128;
  localparam int unsigned BL      = 16;
  localparam int unsigned DEPTH   = 256;
  localparam int unsigned SRC_W   = 2;

  logic                       aclk = 1'b0;
  logic                       aresetn;
  logic [NUM_SRC*TDW-1:0]     S_AXIS_TDATA;
  logic [NUM_SRC-1:0]         S_AXIS_TVALID;
  logic [NUM_SRC-1:0]         S_AXIS_TREADY;
  logic [TDW-1:0]             M_AXIS_TDATA;
  logic                       M_AXIS_TVALID;
  logic                       M_AXIS_TREADY;
  logic [31:0]                fifo_data_count;
  logic [SRC_W-1:0]           grant_id;
  logic                       burst_active;
  logic [31:0]                burst_count;

  always #5 aclk = ~aclk;

  axis_fifo_burst_arbiter #(
    .NUM_SRC     (NUM_SRC),
    .TDATA_WIDTH (TDW),
    .BURST_LEN   (BL),
    .FIFO_DEPTH  (DEPTH),
    .SRC_W       (SRC_W)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .S_AXIS_TDATA    (S_AXIS_TDATA),
    .S_AXIS_TVALID   (S_AXIS_TVALID),
    .S_AXIS_TREADY   (S_AXIS_TREADY),
    .M_AXIS_TDATA    (M_AXIS_TDATA),
    .M_AXIS_TVALID   (M_AXIS_TVALID),
    .M_AXIS_TREADY   (M_AXIS_TREADY),
    .fifo_data_count (fifo_data_count),
    .grant_id        (grant_id),
    .burst_active    (burst_active),
    .burst_count     (burst_count)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Stimulus state per source
  int unsigned  seq  [NUM_SRC];
  int           left [NUM_SRC];   // beats still to offer, -1 = endless
  bit           en   [NUM_SRC];
  bit           drop [NUM_SRC];
  logic [127:0] base [NUM_SRC];
  bit           hs   [NUM_SRC];
  bit           rand_mode;
  bit           bp_mode;
  int           bp_phase;
  bit           mready;
  logic [31:0]  count;

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      S_AXIS_TVALID[i] = en[i] && (left[i] != 0) && !drop[i];
      S_AXIS_TDATA[i*TDW +: TDW] = base[i] + 128'(seq[i]);
    end
    M_AXIS_TREADY   = mready;
    fifo_data_count = count;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      seq[i] = 0; left[i] = 0; en[i] = 1'b0; drop[i] = 1'b0; base[i] = '0;
    end
    rand_mode = 1'b0; bp_mode = 1'b0; bp_phase = 0; mready = 1'b1; count = '0;
  endtask

  // Advance one cycle: retire handshaken beats, then drive new inputs
  task automatic step();
    @(posedge aclk);
    #1;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (hs[i]) begin
        seq[i]++;
        if (left[i] > 0) left[i]--;
      end
    end
    if (rand_mode) begin
      for (int i = 0; i < int'(NUM_SRC); i++) drop[i] = ($urandom_range(0, 29) == 0);
      mready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) count = 32'($urandom_range(200, 256));
    end
    if (bp_mode) begin
      mready = ((bp_phase % 4) == 0) || ((bp_phase % 4) == 3);
      bp_phase++;
    end
    apply();
  endtask

  task automatic sample();
    @(negedge aclk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    clear_stim();
    apply();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  // Behavioural model: who owns the port, how many beats so far, quiet cycles left
  int          m_owner = -1;
  int          m_gid   = 0;
  int          m_beats = 0;
  int          m_quiet = 0;
  int          m_ptr   = 0;
  logic [31:0] m_bursts = '0;

  logic                e_tv;
  logic [TDW-1:0]      e_td;
  logic [NUM_SRC-1:0]  e_tr;

  task automatic end_burst();
    m_ptr    = (m_owner + 1) % int'(NUM_SRC);
    m_bursts = m_bursts + 32'd1;
    m_quiet  = 2;
    m_owner  = -1;
    m_beats  = 0;
  endtask

  // Compare every cycle, then advance the model by what the coming edge does
  always @(negedge aclk) begin
    for (int i = 0; i < int'(NUM_SRC); i++) hs[i] = S_AXIS_TVALID[i] && S_AXIS_TREADY[i];
    if (aresetn !== 1'b1) begin
      m_owner = -1; m_gid = 0; m_beats = 0; m_quiet = 0; m_ptr = 0; m_bursts = '0;
    end
    e_tv = 1'b0; e_td = '0; e_tr = '0;
    if (m_owner >= 0) begin
      e_tv = S_AXIS_TVALID[SRC_W'(m_owner)];
      e_td = base[m_owner] + 128'(seq[m_owner]);
      e_tr[SRC_W'(m_owner)] = M_AXIS_TREADY;
    end
    cmp("m_tvalid",     128'(M_AXIS_TVALID), 128'(e_tv));
    cmp("m_tdata",      128'(M_AXIS_TDATA),  128'(e_td));
    cmp("s_tready",     128'(S_AXIS_TREADY), 128'(e_tr));
    cmp("grant_id",     128'(grant_id),      128'(m_gid));
    cmp("burst_active", 128'(burst_active),  128'(m_owner >= 0));
    cmp("burst_count",  128'(burst_count),   128'(m_bursts));
    if (aresetn === 1'b1) begin
      if (m_owner >= 0) begin
        if (!S_AXIS_TVALID[SRC_W'(m_owner)]) begin
          end_burst();
        end else if (M_AXIS_TREADY) begin
          m_beats++;
          if (m_beats == int'(BL)) end_burst();
        end
      end else if (m_quiet > 0) begin
        m_quiet--;
      end else if (S_AXIS_TVALID != '0 && (32'(DEPTH) - fifo_data_count) >= 32'(BL)) begin
        for (int k = 0; k < int'(NUM_SRC); k++) begin
          if (m_owner < 0 && S_AXIS_TVALID[SRC_W'((m_ptr + k) % int'(NUM_SRC))])
            m_owner = (m_ptr + k) % int'(NUM_SRC);
        end
        m_gid   = m_owner;
        m_beats = 0;
      end
    end
  end

  logic [127:0] beats_q [$];
  int           starts  [$];
  int           first_gid;
  bit           prev_ba;
  int           nbeat;
  int           exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset and single source
    aresetn = 1'b0;
    clear_stim();
    en[2] = 1'b1; left[2] = 16; base[2] = 128'h10;
    apply();
    sample();
    cmp("rst_tready", 128'(S_AXIS_TREADY), 128'h0);
    cmp("rst_tvalid", 128'(M_AXIS_TVALID), 128'h0);
    cmp("rst_tdata",  128'(M_AXIS_TDATA),  128'h0);
    cmp("rst_bcount", 128'(burst_count),   128'h0);
    cmp("rst_active", 128'(burst_active),  128'h0);
    sample();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    beats_q.delete();
    first_gid = -1;
    repeat (40) begin
      step();
      sample();
      if (M_AXIS_TVALID && M_AXIS_TREADY) beats_q.push_back(M_AXIS_TDATA);
      if (burst_active && first_gid < 0) first_gid = int'(grant_id);
    end
    cmp("single_gid",   128'(first_gid),      128'd2);
    cmp("single_beats", 128'(beats_q.size()), 128'd16);
    for (int k = 0; k < beats_q.size(); k++) cmp("single_data", beats_q[k], 128'(32'h10 + k));
    cmp("single_bcount", 128'(burst_count), 128'd1);

    // Round-robin fairness
    do_reset();
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      en[i] = 1'b1; left[i] = -1; base[i] = 128'(i) << 64;
    end
    apply();
    starts.delete();
    prev_ba = 1'b0;
    repeat (130) begin
      step();
      sample();
      if (burst_active && !prev_ba) starts.push_back(int'(grant_id));
      prev_ba = burst_active;
    end
    cmp("rr_nstarts", 128'(starts.size() >= 5), 128'd1);
    for (int k = 0; k < 5 && k < starts.size(); k++) cmp("rr_order", 128'(starts[k]), 128'(exp_order[k]));

    // Space gating
    do_reset();
    count = 32'd241; en[0] = 1'b1; left[0] = -1;
    apply();
    repeat (10) begin
      step();
      sample();
    end
    cmp("gate_241", 128'(burst_active), 128'd0);
    step();
    count = 32'd240;
    apply();
    step();
    sample();
    cmp("gate_240", 128'(burst_active), 128'd1);

    // Early termination after 5 beats, pointer then moves to source 2
    do_reset();
    en[1] = 1'b1; left[1] = 5; base[1] = 128'h100;
    apply();
    nbeat = 0;
    repeat (20) begin
      step();
      sample();
      if (M_AXIS_TVALID && M_AXIS_TREADY) nbeat++;
    end
    cmp("early_beats",  128'(nbeat),       128'd5);
    cmp("early_bcount", 128'(burst_count), 128'd1);
    step();
    en[0] = 1'b1; left[0] = -1; en[2] = 1'b1; left[2] = -1;
    apply();
    first_gid = -1;
    repeat (10) begin
      step();
      sample();
      if (burst_active && first_gid < 0) first_gid = int'(grant_id);
    end
    cmp("early_next_gid", 128'(first_gid), 128'd2);

    // Backpressure pattern 1,0,0,1
    do_reset();
    en[3] = 1'b1; left[3] = 16; base[3] = 128'h300;
    bp_mode = 1'b1;
    apply();
    beats_q.delete();
    repeat (80) begin
      step();
      sample();
      if (M_AXIS_TVALID && M_AXIS_TREADY) beats_q.push_back(M_AXIS_TDATA);
    end
    cmp("bp_beats", 128'(beats_q.size()), 128'd16);
    for (int k = 0; k < beats_q.size(); k++) cmp("bp_data", beats_q[k], 128'(32'h300 + k));

    // Mid-burst reset after 7 beats
    do_reset();
    en[0] = 1'b1; left[0] = -1; base[0] = 128'h700;
    apply();
    nbeat = 0;
    for (int c = 0; c < 50 && nbeat < 7; c++) begin
      step();
      sample();
      if (M_AXIS_TVALID && M_AXIS_TREADY) nbeat++;
    end
    cmp("mid_beats", 128'(nbeat), 128'd7);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    sample();
    cmp("mid_tready", 128'(S_AXIS_TREADY), 128'h0);
    cmp("mid_tvalid", 128'(M_AXIS_TVALID), 128'h0);
    cmp("mid_gid",    128'(grant_id),      128'h0);
    cmp("mid_bcount", 128'(burst_count),   128'h0);

    // Randomized traffic, checked by the model every cycle
    do_reset();
    rand_mode = 1'b1;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      en[i] = 1'b1; left[i] = -1; base[i] = 128'(i + 1) << 64;
    end
    count = 32'd0;
    apply();
    repeat (3000) step();
    sample();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_axis_fifo_burst_arbiter
